// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational 8-bit ALU
// between two requesters. Optional macro: ALU_ARB_OPCHECK_EN (opcode 7 trap).
module alu_arbiter #(
    parameter int LAT   = 2,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [2:0] op0,
    input  logic       cin0,
    input  logic       req1,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic [2:0] op1,
    input  logic       cin1,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    output logic       alu_cin,
    input  logic [7:0] alu_r,
    output logic [7:0] res,
    output logic       done0,
    output logic       done1,
`ifdef ALU_ARB_OPCHECK_EN
    output logic       err,
`endif
    output logic       busy,
    output logic       gnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_gnt;
    logic [7:0]       r_alu_a;
    logic [7:0]       r_alu_b;
    logic [2:0]       r_alu_op;
    logic             r_alu_cin;
    logic [7:0]       r_res;
`ifdef ALU_ARB_OPCHECK_EN
    logic             r_err;
`endif

    logic       w_any;
    logic       w_pick1;
    logic [7:0] w_a;
    logic [7:0] w_b;
    logic [2:0] w_op;
    logic       w_cin;

    // Round-robin pick: on a tie the channel not granted last time wins.
    always_comb begin
        w_any   = req0 | req1;
        w_pick1 = (req0 & req1) ? ~r_gnt : req1;
        w_a     = w_pick1 ? a1   : a0;
        w_b     = w_pick1 ? b1   : b0;
        w_op    = w_pick1 ? op1  : op0;
        w_cin   = w_pick1 ? cin1 : cin0;
    end

    // Control FSM: accept, hold ALU inputs while they settle, return result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_gnt     <= 1'b1;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_alu_cin <= 1'b0;
            r_res     <= '0;
`ifdef ALU_ARB_OPCHECK_EN
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt <= w_pick1;
`ifdef ALU_ARB_OPCHECK_EN
                        if (w_op == 3'b111) begin
                            r_res   <= 8'h00;
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else
`endif
                        begin
                            r_alu_a   <= w_a;
                            r_alu_b   <= w_b;
                            r_alu_op  <= w_op;
                            r_alu_cin <= w_cin;
                            r_cnt     <= CNT_INIT;
                            r_state   <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (r_cnt == '0) begin
                        r_res   <= alu_r;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
`ifdef ALU_ARB_OPCHECK_EN
                    r_err   <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;
    assign alu_op  = r_alu_op;
    assign alu_cin = r_alu_cin;
    assign res     = r_res;
    assign gnt     = r_gnt;
    assign busy    = (r_state != S_IDLE);
    assign done0   = (r_state == S_DONE) & ~r_gnt;
    assign done1   = (r_state == S_DONE) & r_gnt;
`ifdef ALU_ARB_OPCHECK_EN
    assign err     = r_err;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector bench for alu_arbiter with a stub
// adder ALU (R = A + B + cin).
module tb_alu_arbiter;

    localparam int LAT = 2;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] a0, b0, a1, b1;
    logic [2:0] op0, op1;
    logic       cin0, cin1;
    logic [7:0] alu_a, alu_b, alu_r, res;
    logic [2:0] alu_op;
    logic       alu_cin;
    logic       done0, done1, busy, gnt;
`ifdef ALU_ARB_OPCHECK_EN
    logic       err;
`endif

    int n_chk;
    int n_fail;

    alu_arbiter #(.LAT(LAT), .CNT_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .a0     (a0),
        .b0     (b0),
        .op0    (op0),
        .cin0   (cin0),
        .req1   (req1),
        .a1     (a1),
        .b1     (b1),
        .op1    (op1),
        .cin1   (cin1),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_op (alu_op),
        .alu_cin(alu_cin),
        .alu_r  (alu_r),
        .res    (res),
        .done0  (done0),
        .done1  (done1),
`ifdef ALU_ARB_OPCHECK_EN
        .err    (err),
`endif
        .busy   (busy),
        .gnt    (gnt)
    );

    // Stub ALU
    assign alu_r = alu_a + alu_b + {7'd0, alu_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       cin;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input string nm, output int k, output int ch);
        k  = 0;
        ch = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done0 | done1) begin
                k  = i;
                ch = done1 ? 1 : 0;
                chk({nm, "_onehot"}, {done0, done1} == 2'b11, 0);
                break;
            end
        end
        if (ch < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no done expected done", nm);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_op(input vec_t v);
        int         k, ch, exp_k;
        logic [7:0] exp_a, exp_b, exp_r;
        logic [2:0] exp_op;
        logic       exp_cin;
        exp_a   = v.a;
        exp_b   = v.b;
        exp_op  = v.op;
        exp_cin = v.cin;
        exp_r   = v.exp_res;
        exp_k   = LAT;
        @(negedge clk);
`ifdef ALU_ARB_OPCHECK_EN
        if (v.op == 3'b111) begin
            exp_a   = alu_a;
            exp_b   = alu_b;
            exp_op  = alu_op;
            exp_cin = alu_cin;
            exp_r   = 8'h00;
            exp_k   = 1;
        end
`endif
        if (v.ch == 0) begin
            req0 = 1'b1; a0 = v.a; b0 = v.b; op0 = v.op; cin0 = v.cin;
        end else begin
            req1 = 1'b1; a1 = v.a; b1 = v.b; op1 = v.op; cin1 = v.cin;
        end
        @(posedge clk);
        #1;
        chk("acc_gnt", gnt, v.ch);
        chk("acc_busy", busy, 1);
        chk("acc_alu_a", alu_a, exp_a);
        chk("acc_alu_b", alu_b, exp_b);
        chk("acc_alu_op", alu_op, exp_op);
        chk("acc_alu_cin", alu_cin, exp_cin);
        req0 = 1'b0;
        req1 = 1'b0;
        a0 = 8'hEE; b0 = 8'hEE; a1 = 8'hDD; b1 = 8'hDD;
        if (exp_k > 1) begin
            @(posedge clk);
            #1;
            chk("hold_alu_a", alu_a, exp_a);
            chk("early_done", done0 | done1, 0);
            for (int i = 2; i < exp_k; i++) begin
                @(posedge clk);
                #1;
            end
            k = exp_k - 1;
            wait_done("op", k, ch);
            k = k + exp_k - 1;
        end else begin
            wait_done("op", k, ch);
        end
        chk("op_latency", k, exp_k);
        chk("op_done_ch", ch, v.ch);
        chk("op_res", res, exp_r);
`ifdef ALU_ARB_OPCHECK_EN
        chk("op_err", err, (v.op == 3'b111));
`endif
        @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done0 | done1, 0);
        chk("idle_res", res, exp_r);
`ifdef ALU_ARB_OPCHECK_EN
        chk("idle_err", err, 0);
`endif
    endtask

    int t_done[$];
    int c_done[$];

    initial begin
        int k, ch, cyc;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        req0 = 1'b0; a0 = '0; b0 = '0; op0 = '0; cin0 = 1'b0;
        req1 = 1'b0; a1 = '0; b1 = '0; op1 = '0; cin1 = 1'b0;

        vecs[0] = '{0, 8'h14, 8'h06, 3'd0, 1'b0, 8'h1A};
        vecs[1] = '{1, 8'hFF, 8'h01, 3'd3, 1'b0, 8'h00};
        vecs[2] = '{0, 8'h80, 8'h7F, 3'd5, 1'b1, 8'h00};
        vecs[3] = '{1, 8'h14, 8'h06, 3'd2, 1'b1, 8'h1B};
        vecs[4] = '{0, 8'h14, 8'h06, 3'd7, 1'b0, 8'h1A};
        vecs[5] = '{1, 8'hA5, 8'h5A, 3'd6, 1'b0, 8'hFF};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", {done0, done1}, 0);
        chk("rst_gnt", gnt, 1);
        chk("rst_res", res, 0);
        chk("rst_alu", {alu_a, alu_b, alu_op, alu_cin}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // table vectors, single requester
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i]);
        end

        // tie after reset: ch0 first, then ch1 with one IDLE cycle
        do_reset();
        req0 = 1'b1; a0 = 8'h11; b0 = 8'h22; op0 = 3'd1; cin0 = 1'b0;
        req1 = 1'b1; a1 = 8'h14; b1 = 8'h06; op1 = 3'd4; cin1 = 1'b1;
        @(posedge clk);
        #1;
        chk("tie_gnt0", gnt, 0);
        chk("tie_alu_a0", alu_a, 8'h11);
        @(negedge clk);
        req0 = 1'b0;
        wait_done("tie0", k, ch);
        chk("tie_lat0", k, LAT);
        chk("tie_ch0", ch, 0);
        chk("tie_res0", res, 8'h33);
        @(posedge clk);
        #1;
        chk("tie_gap_idle", busy, 0);
        @(posedge clk);
        #1;
        chk("tie_gnt1", gnt, 1);
        chk("tie_busy1", busy, 1);
        chk("tie_alu_a1", alu_a, 8'h14);
        @(negedge clk);
        req1 = 1'b0;
        wait_done("tie1", k, ch);
        chk("tie_lat1", k, LAT);
        chk("tie_ch1", ch, 1);
        chk("tie_res1", res, 8'h1B);
        repeat (2) @(posedge clk);

        // continuous contention
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
        cyc = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done0 | done1) begin
                t_done.push_back(cyc);
                c_done.push_back(done1 ? 1 : 0);
                chk("cont_res", res, done1 ? 8'h1B : 8'h33);
            end
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        chk("cont_count", t_done.size() >= 6, 1);
        if (t_done.size() > 0) chk("cont_first", c_done[0], 0);
        for (int i = 1; i < t_done.size(); i++) begin
            chk("cont_alt", c_done[i], 1 - c_done[i-1]);
            chk("cont_gap", t_done[i] - t_done[i-1], LAT + 2);
        end
        repeat (3) @(posedge clk);

        // reset during EXEC
        @(negedge clk);
        req0 = 1'b1; a0 = 8'h30; b0 = 8'h03; op0 = 3'd0; cin0 = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_res", res, 0);
        chk("mid_alu", {alu_a, alu_b, alu_op, alu_cin}, 0);
        chk("mid_busy0", busy, 0);
        chk("mid_gnt", gnt, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("mid_nodone", done0 | done1, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req1 = 1'b1; a1 = 8'h40; b1 = 8'h02; op1 = 3'd2; cin1 = 1'b0;
        @(posedge clk);
        #1;
        chk("post_busy", busy, 1);
        chk("post_gnt", gnt, 1);
        chk("post_alu_a", alu_a, 8'h40);
        @(negedge clk);
        req1 = 1'b0;
        wait_done("post", k, ch);
        chk("post_lat", k, LAT);
        chk("post_ch", ch, 1);
        chk("post_res", res, 8'h42);
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
